// File: rtl/xgmii_rx_measure_pkg.sv
// rtl/xgmii_rx_measure_pkg.sv - XGMII control characters, receiver states and probe layout
// Shared with the probe transmitter so both sides agree on framing and probe offsets.
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'hC0DE_CAFE
`endif

package xgmii_rx_measure_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;

    // Word indices count from the start word (index 0).
    localparam logic [15:0] PROBE_MAGIC_WORD = 16'd6;
    localparam int unsigned PROBE_MAGIC_LANE = 2;
    localparam int unsigned PROBE_TS_HI_LANE = 6;
    localparam logic [15:0] PROBE_TS_LO_WORD = 16'd7;
    localparam int unsigned PROBE_TS_LO_LANE = 0;

    localparam logic [31:0] MIN_FRAME_BYTES = 32'd64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } rx_state_e;

    function automatic logic [7:0] lane_byte(input logic [63:0] d, input int unsigned k);
        return d[8*k +: 8];
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/xgmii_rx_measure_term_detect.sv
// rtl/xgmii_rx_measure_term_detect.sv - combinational terminate/error character finder
// Reports the lowest lane carrying a control FD and whether any lane carries a control FE.
module xgmii_term_detect
    import xgmii_rx_measure_pkg::*;
(
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    output logic        term_valid,
    output logic [2:0]  term_lane,
    output logic        err_valid
);

    always_comb begin
        term_valid = 1'b0;
        term_lane  = 3'd0;
        err_valid  = 1'b0;
        // Walk downwards so the lowest matching lane is the one left standing.
        for (int k = 7; k >= 0; k--) begin
            if (rxc[k] && (rxd[8*k +: 8] == XGMII_TERM)) begin
                term_valid = 1'b1;
                term_lane  = 3'(k);
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (rxc[k] && (rxd[8*k +: 8] == XGMII_ERR)) begin
                err_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_rx_measure.sv
// rtl/xgmii_rx_measure.sv - XGMII receive frame/byte rate, probe latency and error counters
// Frames are tracked word by word; all results register one cycle after the terminate word.
module xgmii_rx_measure
    import xgmii_rx_measure_pkg::*;
#(
    parameter logic [31:0] MAGIC_CODE = `MAGIC_CODE,
    parameter logic [15:0] MAX_WORDS  = 16'd1200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic [31:0] rx_probe_cnt,
    output logic [15:0] rx_err_cnt
);

    rx_state_e   state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] magic_q, magic_d;
    logic [31:0] ts_q, ts_d;

    logic [31:0] win_pps_q, win_pps_d;
    logic [31:0] win_bytes_q, win_bytes_d;
    logic [31:0] pps_q, tput_q, probe_q;
    logic [23:0] lat_q;
    logic [15:0] err_q;

    logic        term_valid, err_valid;
    logic [2:0]  term_lane;
    logic        start_word, drop_exit;
    logic [15:0] cur_idx, idx_m1;
    logic [31:0] frame_bytes, lat_diff;
    logic [23:0] lat_sat;
    logic        good_now, abort_now, probe_now;

    xgmii_term_detect u_term_detect (
        .rxd        (xgmii_rxd),
        .rxc        (xgmii_rxc),
        .term_valid (term_valid),
        .term_lane  (term_lane),
        .err_valid  (err_valid)
    );

    assign start_word  = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);
    assign drop_exit   = (&xgmii_rxc) && (xgmii_rxd[7:0] != XGMII_START);
    assign cur_idx     = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
    assign idx_m1      = cur_idx - 16'd1;
    assign frame_bytes = {13'd0, idx_m1, 3'd0} + {29'd0, term_lane};

    // Timestamp difference is modulo 2^32 so counter wrap between tx and rx is harmless.
    assign lat_diff  = global_counter - ts_q;
    assign lat_sat   = (lat_diff[31:24] != 8'd0) ? 24'hFF_FFFF : lat_diff[23:0];
    assign probe_now = good_now && (magic_q == MAGIC_CODE);

    assign win_pps_d   = sat_add32(win_pps_q, {31'd0, good_now});
    assign win_bytes_d = sat_add32(win_bytes_q, good_now ? frame_bytes : 32'd0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        magic_d   = magic_q;
        ts_d      = ts_q;
        good_now  = 1'b0;
        abort_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_word) begin
                    state_d = ST_FRAME;
                    idx_d   = 16'd0;
                end
            end
            ST_FRAME: begin
                idx_d = cur_idx;
                if (err_valid) begin
                    state_d   = ST_DROP;
                    abort_now = 1'b1;
                end else if (start_word) begin
                    // Abort the old frame and treat this word as the start of the next.
                    state_d   = ST_FRAME;
                    idx_d     = 16'd0;
                    abort_now = 1'b1;
                end else if (cur_idx > MAX_WORDS) begin
                    state_d   = ST_DROP;
                    abort_now = 1'b1;
                end else if (term_valid) begin
                    state_d = ST_IDLE;
                    if (frame_bytes >= MIN_FRAME_BYTES) begin
                        good_now = 1'b1;
                    end else begin
                        abort_now = 1'b1;
                    end
                end else begin
                    if (cur_idx == PROBE_MAGIC_WORD) begin
                        magic_d = {lane_byte(xgmii_rxd, PROBE_MAGIC_LANE),
                                   lane_byte(xgmii_rxd, PROBE_MAGIC_LANE + 1),
                                   lane_byte(xgmii_rxd, PROBE_MAGIC_LANE + 2),
                                   lane_byte(xgmii_rxd, PROBE_MAGIC_LANE + 3)};
                        ts_d[31:16] = {lane_byte(xgmii_rxd, PROBE_TS_HI_LANE),
                                       lane_byte(xgmii_rxd, PROBE_TS_HI_LANE + 1)};
                    end
                    if (cur_idx == PROBE_TS_LO_WORD) begin
                        ts_d[15:0] = {lane_byte(xgmii_rxd, PROBE_TS_LO_LANE),
                                      lane_byte(xgmii_rxd, PROBE_TS_LO_LANE + 1)};
                    end
                end
            end
            ST_DROP: begin
                if (start_word) begin
                    state_d = ST_FRAME;
                    idx_d   = 16'd0;
                end else if (drop_exit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 16'd0;
            magic_q <= 32'd0;
            ts_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            magic_q <= magic_d;
            ts_q    <= ts_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            win_pps_q   <= 32'd0;
            win_bytes_q <= 32'd0;
            pps_q       <= 32'd0;
            tput_q      <= 32'd0;
            probe_q     <= 32'd0;
            lat_q       <= 24'd0;
            err_q       <= 16'd0;
        end else begin
            if (abort_now && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
            if (probe_now) begin
                probe_q <= probe_q + 32'd1;
                lat_q   <= lat_sat;
            end
            // A frame ending on the window edge belongs to the window being closed.
            if (sec_oneshot) begin
                pps_q       <= win_pps_d;
                tput_q      <= win_bytes_d;
                win_pps_q   <= 32'd0;
                win_bytes_q <= 32'd0;
            end else begin
                win_pps_q   <= win_pps_d;
                win_bytes_q <= win_bytes_d;
            end
        end
    end

    assign rx_pps        = pps_q;
    assign rx_throughput = tput_q;
    assign rx_latency    = lat_q;
    assign rx_probe_cnt  = probe_q;
    assign rx_err_cnt    = err_q;

endmodule

// File: tb/tb_xgmii_rx_measure.sv
// tb/tb_xgmii_rx_measure.sv - self-checking bench for xgmii_rx_measure
module tb_xgmii_rx_measure;

    localparam logic [31:0] MAGIC     = 32'hC0DE_CAFE;
    localparam int          MAXW      = 1200;
    localparam logic [63:0] IDLE_WORD = {8{8'h07}};

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        sec_oneshot;
    logic [31:0] global_counter;
    logic [31:0] rx_pps, rx_throughput, rx_probe_cnt;
    logic [23:0] rx_latency;
    logic [15:0] rx_err_cnt;

    always #5 sys_clk = ~sys_clk;

    xgmii_rx_measure #(.MAGIC_CODE(MAGIC), .MAX_WORDS(16'(MAXW))) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .sec_oneshot    (sec_oneshot),
        .global_counter (global_counter),
        .rx_pps         (rx_pps),
        .rx_throughput  (rx_throughput),
        .rx_latency     (rx_latency),
        .rx_probe_cnt   (rx_probe_cnt),
        .rx_err_cnt     (rx_err_cnt)
    );

    int pass_cnt = 0;
    int check_cnt = 0;

    longint unsigned m_pps, m_tput, m_win_pps, m_win_bytes;
    logic [31:0]     m_probe;
    logic [23:0]     m_lat;
    int              m_err;

    task automatic model_reset();
        m_pps = 0; m_tput = 0; m_win_pps = 0; m_win_bytes = 0;
        m_probe = 32'd0; m_lat = 24'd0; m_err = 0;
    endtask

    task automatic model_close_window();
        m_pps = m_win_pps; m_tput = m_win_bytes;
        m_win_pps = 0; m_win_bytes = 0;
    endtask

    task automatic model_frame(input int nbytes, input logic [31:0] magic, input logic [31:0] ts,
                               input bit aborted, input logic [31:0] term_gc, input bit sec_term);
        logic [31:0] diff;
        if (aborted || nbytes < 64 || (nbytes / 8 + 1) > MAXW) begin
            if (m_err < 65535) m_err++;
        end else begin
            m_win_pps   = (m_win_pps + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_win_pps + 1;
            m_win_bytes = (m_win_bytes + nbytes > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_win_bytes + nbytes;
            if (magic == MAGIC) begin
                m_probe = m_probe + 32'd1;
                diff    = term_gc - ts;
                m_lat   = (diff > 32'h00FF_FFFF) ? 24'hFF_FFFF : diff[23:0];
            end
        end
        if (sec_term) model_close_window();
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        global_counter = global_counter + 32'd1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] c, input logic s);
        xgmii_rxd   = d;
        xgmii_rxc   = c;
        sec_oneshot = s;
        tick();
        sec_oneshot = 1'b0;
    endtask

    task automatic idle_words(input int n);
        for (int i = 0; i < n; i++) send_word(IDLE_WORD, 8'hFF, 1'b0);
    endtask

    task automatic sec_pulse();
        send_word(IDLE_WORD, 8'hFF, 1'b1);
        model_close_window();
    endtask

    // nbytes covers DA..FCS; magic/ts land at frame bytes 42..49.
    task automatic send_frame(input int nbytes, input logic [31:0] magic, input logic [31:0] ts,
                              input int err_word, input int cut_words, input bit force_gc,
                              input logic [31:0] gc_val, input bit sec_term,
                              output logic [31:0] term_gc);
        byte unsigned pl[];
        logic [63:0]  pb;
        logic [63:0]  d;
        logic [7:0]   c;
        int           last_w;
        int           b;
        pl = new[nbytes];
        foreach (pl[i]) pl[i] = 8'($urandom);
        pb = {magic, ts};
        for (int i = 0; i < 8; i++) if (42 + i < nbytes) pl[42 + i] = pb[63 - 8*i -: 8];
        term_gc = global_counter;
        last_w  = nbytes / 8 + 1;
        for (int w = 0; w <= last_w; w++) begin
            if (cut_words > 0 && w >= cut_words) break;
            if (w == 0) begin
                d = 64'hD555_5555_5555_55FB;
                c = 8'h01;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    b = 8*(w-1) + k;
                    if (b < nbytes) begin
                        d[8*k +: 8] = pl[b]; c[k] = 1'b0;
                    end else if (b == nbytes) begin
                        d[8*k +: 8] = 8'hFD; c[k] = 1'b1;
                    end else begin
                        d[8*k +: 8] = 8'h07; c[k] = 1'b1;
                    end
                end
                if (w == err_word) begin
                    d[31:24] = 8'hFE; c[3] = 1'b1;
                end
            end
            if (w == last_w) begin
                if (force_gc) global_counter = gc_val;
                term_gc = global_counter;
            end
            send_word(d, c, (w == last_w) && sec_term);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        idle_words(3);
        model_reset();
        check_cnt++; if (rx_pps !== 32'd0) $display("FAIL reset_pps: got %0d want 0", rx_pps); else pass_cnt++;
        check_cnt++; if (rx_throughput !== 32'd0) $display("FAIL reset_tput: got %0d want 0", rx_throughput); else pass_cnt++;
        check_cnt++; if (rx_latency !== 24'd0) $display("FAIL reset_lat: got %0d want 0", rx_latency); else pass_cnt++;
        check_cnt++; if (rx_probe_cnt !== 32'd0) $display("FAIL reset_probe: got %0d want 0", rx_probe_cnt); else pass_cnt++;
        check_cnt++; if (rx_err_cnt !== 16'd0) $display("FAIL reset_err: got %0d want 0", rx_err_cnt); else pass_cnt++;
        sys_rst_n = 1'b1;
        idle_words(2);
    endtask

    task automatic test_probe_latency();
        logic [31:0] tg;
        send_frame(64, MAGIC, 32'd100, -1, 0, 1'b1, 32'd130, 1'b0, tg);
        model_frame(64, MAGIC, 32'd100, 1'b0, tg, 1'b0);
        check_cnt++; if (rx_latency !== 24'd30) $display("FAIL probe_latency: got %0d want 30", rx_latency); else pass_cnt++;
        check_cnt++; if (rx_probe_cnt !== 32'd1) $display("FAIL probe_cnt: got %0d want 1", rx_probe_cnt); else pass_cnt++;
        idle_words(2);
    endtask

    task automatic test_window();
        logic [31:0] tg;
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'd1 || rx_throughput !== 32'd64)
            $display("FAIL window_first: got %0d/%0d want 1/64", rx_pps, rx_throughput); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            send_frame(64, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
            model_frame(64, 32'd0, 32'd0, 1'b0, tg, 1'b0);
            idle_words(1);
        end
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'd3) $display("FAIL window_pps: got %0d want 3", rx_pps); else pass_cnt++;
        check_cnt++; if (rx_throughput !== 32'd192) $display("FAIL window_tput: got %0d want 192", rx_throughput); else pass_cnt++;
        idle_words(4);
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'd0 || rx_throughput !== 32'd0)
            $display("FAIL window_empty: got %0d/%0d want 0/0", rx_pps, rx_throughput); else pass_cnt++;
    endtask

    task automatic test_latency_wrap();
        logic [31:0] tg;
        send_frame(80, MAGIC, 32'hFFFF_FFF0, -1, 0, 1'b1, 32'h10, 1'b0, tg);
        model_frame(80, MAGIC, 32'hFFFF_FFF0, 1'b0, tg, 1'b0);
        check_cnt++; if (rx_latency !== 24'd32) $display("FAIL lat_wrap: got %0d want 32", rx_latency); else pass_cnt++;
        idle_words(1);
        send_frame(64, MAGIC, 32'h1034_0000, -1, 0, 1'b1, 32'h1234_0000, 1'b0, tg);
        model_frame(64, MAGIC, 32'h1034_0000, 1'b0, tg, 1'b0);
        check_cnt++; if (rx_latency !== 24'hFF_FFFF) $display("FAIL lat_sat: got %h want ffffff", rx_latency); else pass_cnt++;
        check_cnt++; if (rx_probe_cnt !== 32'd3) $display("FAIL lat_probe_cnt: got %0d want 3", rx_probe_cnt); else pass_cnt++;
        idle_words(1);
        sec_pulse();
    endtask

    task automatic test_abort();
        logic [31:0] tg;
        send_frame(64, MAGIC, 32'd5, 4, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(64, MAGIC, 32'd5, 1'b1, tg, 1'b0);
        idle_words(1);
        check_cnt++; if (rx_err_cnt !== 16'd1) $display("FAIL abort_err: got %0d want 1", rx_err_cnt); else pass_cnt++;
        check_cnt++; if (rx_probe_cnt !== 32'd3) $display("FAIL abort_probe: got %0d want 3", rx_probe_cnt); else pass_cnt++;
        send_frame(64, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(64, 32'd0, 32'd0, 1'b0, tg, 1'b0);
        idle_words(1);
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'd1 || rx_throughput !== 32'd64)
            $display("FAIL abort_window: got %0d/%0d want 1/64", rx_pps, rx_throughput); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] tg;
        send_frame(100, 32'd0, 32'd0, -1, 5, 1'b0, 32'd0, 1'b0, tg);
        model_frame(100, 32'd0, 32'd0, 1'b1, tg, 1'b0);
        send_frame(72, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(72, 32'd0, 32'd0, 1'b0, tg, 1'b0);
        send_frame(80, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(80, 32'd0, 32'd0, 1'b0, tg, 1'b0);
        idle_words(1);
        check_cnt++; if (rx_err_cnt !== 16'd2) $display("FAIL b2b_err: got %0d want 2", rx_err_cnt); else pass_cnt++;
        check_cnt++; if (rx_probe_cnt !== 32'd3) $display("FAIL b2b_probe: got %0d want 3", rx_probe_cnt); else pass_cnt++;
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'd2 || rx_throughput !== 32'd152)
            $display("FAIL b2b_window: got %0d/%0d want 2/152", rx_pps, rx_throughput); else pass_cnt++;
    endtask

    task automatic test_boundaries();
        logic [31:0] tg;
        send_frame(63, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(63, 32'd0, 32'd0, 1'b0, tg, 1'b0);
        idle_words(1);
        check_cnt++; if (rx_err_cnt !== 16'd3) $display("FAIL short_err: got %0d want 3", rx_err_cnt); else pass_cnt++;
        send_frame(9599, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(9599, 32'd0, 32'd0, 1'b0, tg, 1'b0);
        idle_words(1);
        send_frame(9600, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(9600, 32'd0, 32'd0, 1'b0, tg, 1'b0);
        idle_words(2);
        check_cnt++; if (rx_err_cnt !== 16'd4) $display("FAIL oversize_err: got %0d want 4", rx_err_cnt); else pass_cnt++;
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'd1 || rx_throughput !== 32'd9599)
            $display("FAIL max_window: got %0d/%0d want 1/9599", rx_pps, rx_throughput); else pass_cnt++;
        send_frame(70, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b1, tg);
        model_frame(70, 32'd0, 32'd0, 1'b0, tg, 1'b1);
        check_cnt++; if (rx_pps !== 32'd1 || rx_throughput !== 32'd70)
            $display("FAIL straddle_window: got %0d/%0d want 1/70", rx_pps, rx_throughput); else pass_cnt++;
        idle_words(1);
    endtask

    task automatic test_random();
        logic [31:0] tg;
        for (int n = 0; n < 40; n++) begin
            int          nb;
            int          ew;
            bit          st;
            logic [31:0] mg, ts, gv;
            nb = $urandom_range(40, 260);
            mg = ($urandom_range(0, 1) == 1) ? MAGIC : $urandom;
            gv = $urandom;
            ts = gv - $urandom_range(0, 32'h0200_0000);
            ew = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, nb / 8)) : -1;
            st = ($urandom_range(0, 4) == 0);
            send_frame(nb, mg, ts, ew, 0, 1'b1, gv, st, tg);
            model_frame(nb, mg, ts, ew >= 0, tg, st);
            idle_words($urandom_range(1, 3));
            check_cnt++; if (rx_err_cnt !== 16'(m_err)) $display("FAIL rand_err[%0d]: got %0d want %0d", n, rx_err_cnt, m_err); else pass_cnt++;
            check_cnt++; if (rx_probe_cnt !== m_probe) $display("FAIL rand_probe[%0d]: got %0d want %0d", n, rx_probe_cnt, m_probe); else pass_cnt++;
            check_cnt++; if (rx_latency !== m_lat) $display("FAIL rand_lat[%0d]: got %0d want %0d", n, rx_latency, m_lat); else pass_cnt++;
            if (st) begin
                check_cnt++; if (rx_pps !== 32'(m_pps) || rx_throughput !== 32'(m_tput))
                    $display("FAIL rand_window[%0d]: got %0d/%0d want %0d/%0d", n, rx_pps, rx_throughput, m_pps, m_tput); else pass_cnt++;
            end
        end
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'(m_pps) || rx_throughput !== 32'(m_tput))
            $display("FAIL rand_final_window: got %0d/%0d want %0d/%0d", rx_pps, rx_throughput, m_pps, m_tput); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] tg;
        send_frame(64, MAGIC, 32'd0, -1, 3, 1'b0, 32'd0, 1'b0, tg);
        xgmii_rxd = {$urandom, $urandom};
        xgmii_rxc = 8'h00;
        sys_rst_n = 1'b0;
        tick();
        model_reset();
        check_cnt++; if ({rx_pps, rx_throughput, rx_latency, rx_probe_cnt, rx_err_cnt} !== 136'd0)
            $display("FAIL midreset_zero: got %0d/%0d/%0d/%0d/%0d want all 0",
                     rx_pps, rx_throughput, rx_latency, rx_probe_cnt, rx_err_cnt); else pass_cnt++;
        sys_rst_n = 1'b1;
        idle_words(2);
        send_frame(64, 32'd0, 32'd0, -1, 0, 1'b0, 32'd0, 1'b0, tg);
        model_frame(64, 32'd0, 32'd0, 1'b0, tg, 1'b0);
        idle_words(1);
        sec_pulse();
        check_cnt++; if (rx_pps !== 32'd1) $display("FAIL midreset_pps: got %0d want 1", rx_pps); else pass_cnt++;
        check_cnt++; if (rx_err_cnt !== 16'd0) $display("FAIL midreset_err: got %0d want 0", rx_err_cnt); else pass_cnt++;
    endtask

    initial begin
        sys_rst_n      = 1'b0;
        xgmii_rxd      = IDLE_WORD;
        xgmii_rxc      = 8'hFF;
        sec_oneshot    = 1'b0;
        global_counter = 32'd0;
        model_reset();
        test_reset();
        test_probe_latency();
        test_window();
        test_latency_wrap();
        test_abort();
        test_back_to_back();
        test_boundaries();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/xgmii_rx_measure.md
XGMII_RX_MEASURE -- requirements
Module: xgmii_rx_measure

Interface
REQ-001 Parameter MAGIC_CODE, default `MAGIC_CODE (32-bit), the probe-frame signature.
REQ-002 Parameter MAX_WORDS, default 16'd1200, the word count beyond which a frame is declared oversize.
REQ-003 sys_clk  in  1  the single clock (156.25 MHz); all logic runs on its rising edge.
REQ-004 sys_rst_n  in  1  reset; synchronous and active-low.
REQ-005 xgmii_rxd  in  64  XGMII receive data; lane k = bits [8k+7:8k].
REQ-006 xgmii_rxc  in  8  XGMII receive control; bit k flags lane k.
REQ-007 sec_oneshot  in  1  one-cycle pulse that closes each 1 s window.
REQ-008 global_counter  in  32  free-running timestamp, shared with the transmitter.
REQ-009 rx_pps  out  32  good frames counted in the last closed window.
REQ-010 rx_throughput  out  32  bytes counted in the last closed window.
REQ-011 rx_latency  out  24  latency in clocks of the most recent good probe frame.
REQ-012 rx_probe_cnt  out  32  good probe frames since reset; wraps.
REQ-013 rx_err_cnt  out  16  aborted frames since reset; saturates at 16'hFFFF.

Function
REQ-014 A start word is xgmii_rxc[0]=1 with rxd[7:0]=8'hFB; start in lane 4 is not supported and is ignored.
REQ-015 States: IDLE, FRAME, DROP; IDLE->FRAME on start word; reset -> IDLE.
REQ-016 A word index is 0 on the start word and increments each FRAME cycle, saturating at 16'hFFFF.
REQ-017 Probe capture: word 6 bytes 2..5 form the big-endian magic; word 6 bytes 6..7 form ts[31:16]; word 7 bytes 0..1 form ts[15:0].
REQ-018 In FRAME, the first lane k with rxc[k]=1 and byte 8'hFD terminates the frame; frame bytes = 8*(index-1)+k, covering DA through FCS.
REQ-019 Abort conditions, each -> DROP and rx_err_cnt+1: any lane with rxc[k]=1 and byte 8'hFE; a start word while in FRAME; index > MAX_WORDS.
REQ-020 DROP returns to IDLE on the first word with all rxc=1 and no 8'hFB in lane 0; a start word in DROP goes to FRAME directly.
REQ-021 A good frame is one that terminates per REQ-018 with frame bytes >= 64; frames shorter than that count as errors.
REQ-022 A good frame with magic==MAGIC_CODE is a probe: rx_probe_cnt+1 and rx_latency <= global_counter - ts, computed mod 2^32 at the terminate cycle and saturated to 24'hFFFFFF.
REQ-023 Output latency: rx_latency and the counters update on the cycle after the terminate word (1 register stage).
REQ-024 Window counters accumulate good frames and their bytes, each 32-bit and saturating.
REQ-025 On sec_oneshot, rx_pps and rx_throughput load the window totals including any frame completing in that same cycle; the window counters then restart from 0.
REQ-026 A frame straddling sec_oneshot is counted in the window in which it terminates.

Reset
REQ-027 With sys_rst_n=0, all outputs and window counters are cleared to 0, the state goes to IDLE, and the captured magic and ts are cleared to 0.
REQ-028 Reset asserted mid-frame discards that frame without counting it as an error; the first start word after release begins a fresh frame.

Structure
REQ-029 A shared package holds the XGMII control characters (IDLE 07, START FB, TERM FD, ERR FE), the state encodings, and the probe word and byte offsets; the transmitter uses the same constants.
REQ-030 One sub-module, xgmii_term_detect, is combinational: it takes rxd/rxc and returns term_valid, term_lane[2:0] and err_valid.

Verification
REQ-031 64-byte probe with ts=32'd100 whose terminate word (FD in lane 0) arrives at global_counter=130 -> rx_latency=30 and rx_probe_cnt=1, both one cycle later.
REQ-032 Three 64-byte good frames, then sec_oneshot -> rx_pps=3, rx_throughput=192; the next window with no traffic -> 0/0.
REQ-033 ts=32'hFFFFFFF0 with terminate at global_counter=32'h10 -> rx_latency=32; ts equal to global_counter-2^25 -> rx_latency=24'hFFFFFF.
REQ-034 FE in lane 3 of word 4 -> rx_err_cnt=1, frame not counted; a following good frame is counted normally.
REQ-035 A second start word while in FRAME -> rx_err_cnt+1, and the second frame is counted as good; a frame with magic 32'h0 -> counted in rx_pps, rx_probe_cnt unchanged.
REQ-036 sys_rst_n=0 during word 3 of a frame -> all outputs read 0; after release a full frame -> rx_pps=1 at the next sec_oneshot.
